// File: rtl/shift_rot_seq.sv
// Iterative 32-bit right shift/rotate sequencer: 4-position steps while at
// least 4 positions remain, then 1-position steps, result returned with a done pulse.
module shift_rot_seq #(
  parameter int W  = 32,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          shift_rot,
  input  logic [SW-1:0] r,
  input  logic [W-1:0]  x,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  y
);

  // state | meaning
  // IDLE  | waiting for start; y holds the last result
  // SHIFT | stepping acc toward the result, cnt positions left
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [SW-1:0] STEP4 = SW'(4);
  localparam logic [SW-1:0] STEP1 = SW'(1);

  state_t        state, state_nx;
  logic [W-1:0]  acc;
  logic [SW-1:0] cnt;
  logic          mode;
  logic [W-1:0]  acc_sh4, acc_sh1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  // Rotate feeds the bits leaving the LSB end back in at the MSB end.
  always_comb begin
    acc_sh4 = mode ? {acc[3:0], acc[W-1:4]} : {4'b0000, acc[W-1:4]};
    acc_sh1 = mode ? {acc[0], acc[W-1:1]}   : {1'b0, acc[W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      cnt  <= '0;
      mode <= 1'b0;
      y    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= x;
            cnt  <= r;
            mode <= shift_rot;
          end
        end
        SHIFT: begin
          if (cnt >= STEP4) begin
            acc <= acc_sh4;
            cnt <= cnt - STEP4;
          end else if (cnt != '0) begin
            acc <= acc_sh1;
            cnt <= cnt - STEP1;
          end else begin
            y    <= acc;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rot_seq.sv
// Scoreboard bench for shift_rot_seq: directed requests push expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_shift_rot_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        shift_rot;
  logic [4:0]  r;
  logic [31:0] x;
  logic        busy;
  logic        done;
  logic [31:0] y;

  typedef struct {
    logic [31:0] y;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   n_vec = 0;
  int   n_err = 0;

  shift_rot_seq #(.W(32), .SW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .shift_rot(shift_rot),
    .r(r), .x(x), .busy(busy), .done(done), .y(y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done && busy) begin
        n_vec++; n_err++;
        $display("FAIL done_busy_overlap: done=%b busy=%b, expected not both high", done, busy);
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got done with y=%h, expected no done", y);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result_y", y, e.y);
          check("latency", 32'(cycle - e.acc_cyc), 32'(e.lat));
        end
      end
    end
  end

  // Called just after a negedge; drives start for one cycle.
  task automatic issue(input logic [31:0] xi, input logic [4:0] ri, input logic mi,
                       input logic [31:0] ey, input bit track);
    exp_t e;
    x = xi; r = ri; shift_rot = mi; start = 1'b1;
    if (track) begin
      e.y = ey;
      e.lat = int'(ri / 4) + int'(ri % 4) + 1;
      e.acc_cyc = cycle + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", limit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; shift_rot = 1'b0; r = '0; x = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_y", y, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h8000_0001, 5'd1, 1'b0, 32'h4000_0000, 1); wait_done(20);
    @(negedge clk);
    issue(32'h8000_0001, 5'd1, 1'b1, 32'hC000_0000, 1); wait_done(20);
    @(negedge clk);
    issue(32'hF000_000F, 5'd4, 1'b0, 32'h0F00_0000, 1); wait_done(20);
    @(negedge clk);
    issue(32'hF000_000F, 5'd4, 1'b1, 32'hFF00_0000, 1); wait_done(20);
    @(negedge clk);

    // Long rotate with an ignored start mid-operation.
    issue(32'h0000_0001, 5'd31, 1'b1, 32'h0000_0002, 1);
    repeat (3) @(negedge clk);
    check("busy_mid_op", {31'b0, busy}, 32'h1);
    issue(32'hFFFF_FFFF, 5'd3, 1'b0, 32'h0, 0);
    wait_done(20);
    repeat (6) @(negedge clk);
    check("idle_after_ignored_start", {31'b0, busy}, 32'h0);

    // r=0 then back-to-back start on the done cycle.
    issue(32'hDEAD_BEEF, 5'd0, 1'b0, 32'hDEAD_BEEF, 1);
    wait_done(20);
    issue(32'h0000_00F0, 5'd4, 1'b0, 32'h0000_000F, 1);
    wait_done(20);
    @(negedge clk);

    // Asynchronous reset in the middle of a rotate.
    issue(32'h1234_5678, 5'd20, 1'b1, 32'h0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'b0, busy}, 32'h0);
    check("async_rst_done", {31'b0, done}, 32'h0);
    check("async_rst_y", y, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("no_done_after_rst", {31'b0, busy}, 32'h0);
    issue(32'h1234_5678, 5'd20, 1'b1, 32'h4567_8123, 1);
    wait_done(20);
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
